serial_adder_nbit: RTL and testbench
====================================

// Module: serial_adder_nbit
// PURPOSE
//  Parametrised multi-cycle ripple adder; next generation of the 4-bit full-adder chain.
//  Adds two WIDTH-bit operands plus carry-in DIGIT bits per clock, with a start/busy/done handshake.
//  Reuses one DIGIT-bit full-adder slice instead of WIDTH slices; sits in the datapath alongside the ALU.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; must be a multiple of DIGIT
//  DIGIT  2  bits added per cycle, 1..WIDTH; N = WIDTH/DIGIT RUN cycles per add
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request an add; sampled only in IDLE or DONE
//  x         in   WIDTH  operand A, captured on accepted start
//  y         in   WIDTH  operand B, captured on accepted start
//  carryin   in   1      carry into bit 0, captured on accepted start
//  busy      out  1      high while in RUN
//  done      out  1      one-cycle pulse; result is valid
//  sum       out  WIDTH  result; held stable from done until the next accepted start
//  carryout  out  1      carry out of bit WIDTH-1
//  overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE; busy, done, sum, carryout, overflow all 0; internal count and carry 0.
//  Reset mid-RUN: abort without a done pulse; outputs take reset values on the next edge.
//  FSM: IDLE -start-> RUN; RUN -(count==N-1)-> DONE; DONE -start-> RUN, else IDLE.
//  Accepted start at edge k (IDLE or DONE): latch x, y, carry<=carryin, count<=0.
//   Clear done, sum, carryout and overflow to 0 at the same edge.
//  RUN: each edge, add the low DIGIT bits of the x and y shift registers plus carry.
//   Shift the result digit into sum from the MSB side; shift operands right by DIGIT.
//   Update carry; count++.
//  The last RUN edge also records carry into the MSB, for overflow.
//  Timing: busy high for cycles k+1..k+N; done high only in cycle k+N+1.
//   sum, carryout and overflow are valid from cycle k+N+1.
//  start while busy: ignored; no queueing, and the operation in flight is unaffected.
//  start in the DONE cycle: accepted (back-to-back); done drops and busy rises next cycle.
//  DIGIT==WIDTH: N=1, so the whole add completes in one RUN cycle.
//  Width rule: internal sum is WIDTH+1 bits; no truncation other than the carryout split.
//  Operand inputs may change freely after the accepting edge.
// CONFIGURATION
//  Macro SERIAL_ADDER_SUB_EN.
//  Defined: extra input port sub (1 bit), captured on accepted start.
//   sub=1 computes x + ~y + 1 (x - y); carryin is ignored.
//   carryout=1 means no borrow; overflow uses the signed rule above.
//   sub=0 behaves exactly as the base add.
//  Undefined: no sub port, and the block always adds x + y + carryin.
// TESTING (WIDTH=8, DIGIT=2 unless noted; start accepted at edge k)
//  1: x=0x0F, y=0x01, cin=0 -> busy k+1..k+4; done at k+5; sum=0x10, carryout=0, overflow=0.
//  2: x=0xFF, y=0x01, cin=1 -> sum=0x01, carryout=1, overflow=0.
//   Then x=0x7F, y=0x01, cin=0 -> sum=0x80, carryout=0, overflow=1.
//  3: pulse start with x=0x55 at k+2 while busy -> ignored.
//   First result still delivered; one done pulse only.
//   Then start in the done cycle -> second add runs; done after 4 more busy cycles.
//  4: assert rst at k+2 -> next cycle busy=0, done=0, sum=0, state IDLE; no done pulse follows.
//  5: WIDTH=8, DIGIT=8, x=0x80, y=0x80, cin=0 -> done at k+2; sum=0x00, carryout=1, overflow=1.
//  6: SERIAL_ADDER_SUB_EN defined, sub=1, x=0x05, y=0x07 -> sum=0xFE, carryout=0, overflow=0.
//   Same operands with sub=0 -> sum=0x0C.

Source files
------------

// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: multi-cycle adder that processes DIGIT bits per clock
// through a single DIGIT-bit full-adder slice, with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input (x - y).
module serial_adder_nbit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carryin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0]       dig_a, dig_b;
  logic [DIGIT:0]         dig_sum;
  logic                   msb_cin;
  logic [WIDTH+DIGIT-1:0] sum_shift;
  logic [WIDTH-1:0]       y_cap;
  logic                   carry_cap;

  // Operand capture; subtraction stores ~y and forces carry-in to 1 so the
  // RUN datapath is identical for add and subtract.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    y_cap     = sub ? ~y : y;
    carry_cap = sub ? 1'b1 : carryin;
`else
    y_cap     = y;
    carry_cap = carryin;
`endif
  end

  // Shared DIGIT-bit full-adder slice and result shift path.
  always_comb begin
    dig_a     = x_q[DIGIT-1:0];
    dig_b     = y_q[DIGIT-1:0];
    dig_sum   = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
    msb_cin   = dig_sum[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
    // Concatenate then drop the low DIGIT bits so DIGIT==WIDTH needs no special slice.
    sum_shift = {dig_sum[DIGIT-1:0], sum_q};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          x_d     = x;
          y_d     = y_cap;
          carry_d = carry_cap;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        x_d     = x_q >> DIGIT;
        y_d     = y_q >> DIGIT;
        sum_d   = sum_shift[WIDTH+DIGIT-1:DIGIT];
        carry_d = dig_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          cout_d  = dig_sum[DIGIT];
          ovf_d   = dig_sum[DIGIT] ^ msb_cin;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign carryout = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed testbench for serial_adder_nbit (WIDTH=8 with DIGIT=2 and DIGIT=8).
module tb_serial_adder_nbit;

  logic       clk;
  logic       rst;
  logic       start, start8;
  logic [7:0] x, y;
  logic       carryin;
  logic       sub, sub8;
  logic       busy, done, carryout, overflow;
  logic [7:0] sum;
  logic       busy8, done8, carryout8, overflow8;
  logic [7:0] sum8;

  int n_pass;
  int n_total;

  serial_adder_nbit #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .carryin(carryin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .carryout(carryout), .overflow(overflow)
  );

  serial_adder_nbit #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x), .y(y), .carryin(carryin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .carryout(carryout8), .overflow(overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Accept a start on the DIGIT=2 instance, scramble operands, and wait for done.
  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, output int lat, output int bcnt);
    x = a; y = b; carryin = c; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = ~a; y = ~b; carryin = ~c; sub = ~s;
    lat = 0; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt;
    n_pass = 0; n_total = 0;
    rst = 1'b1; start = 1'b0; start8 = 1'b0; x = '0; y = '0; carryin = 1'b0;
    sub = 1'b0; sub8 = 1'b0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(carryout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven adds.
    for (int i = 0; i < 8; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, lat, bcnt);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd4);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].e_sum));
      chk($sformatf("v%0d_cout", i), 32'(carryout), 32'(vecs[i].e_cout));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_sum_held", i), 32'(sum), 32'(vecs[i].e_sum));
    end

    // Start while busy is ignored; start in done cycle is accepted back-to-back.
    x = 8'h0F; y = 8'h01; carryin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    x = 8'h55; y = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    lat = 2;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_latency", 32'(lat), 32'd4);
    chk("ign_sum", 32'(sum), 32'h10);
    x = 8'h12; y = 8'h34; carryin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = 8'h00; y = 8'h00;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_drop", 32'(done), 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_latency", 32'(lat), 32'd4);
    chk("b2b_sum", 32'(sum), 32'h46);

    // Reset in the middle of RUN aborts without a done pulse.
    @(posedge clk); #1;
    x = 8'hFF; y = 8'hFF; carryin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(carryout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("rst_no_done", 32'(dcnt), 32'd0);

    // DIGIT == WIDTH: single RUN cycle.
    x = 8'h80; y = 8'h80; carryin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; x = 8'h00; y = 8'h00;
    chk("d8_busy", 32'(busy8), 32'd1);
    chk("d8_nodone", 32'(done8), 32'd0);
    @(posedge clk); #1;
    chk("d8_done", 32'(done8), 32'd1);
    chk("d8_sum", 32'(sum8), 32'h00);
    chk("d8_cout", 32'(carryout8), 32'd1);
    chk("d8_ovf", 32'(overflow8), 32'd1);
    x = 8'h7F; y = 8'h01; carryin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("d8b_done", 32'(done8), 32'd1);
    chk("d8b_sum", 32'(sum8), 32'h80);
    chk("d8b_cout", 32'(carryout8), 32'd0);
    chk("d8b_ovf", 32'(overflow8), 32'd1);
    @(posedge clk); #1;

`ifdef SERIAL_ADDER_SUB_EN
    run_add(8'h05, 8'h07, 1'b0, 1'b1, lat, bcnt);
    chk("sub_latency", 32'(lat), 32'd4);
    chk("sub_sum", 32'(sum), 32'hFE);
    chk("sub_cout", 32'(carryout), 32'd0);
    chk("sub_ovf", 32'(overflow), 32'd0);
    run_add(8'h05, 8'h07, 1'b0, 1'b0, lat, bcnt);
    chk("nosub_sum", 32'(sum), 32'h0C);
    run_add(8'h07, 8'h05, 1'b1, 1'b1, lat, bcnt);
    chk("sub_cin_ign_sum", 32'(sum), 32'h02);
    chk("sub_cin_ign_cout", 32'(carryout), 32'd1);
    run_add(8'h80, 8'h01, 1'b0, 1'b1, lat, bcnt);
    chk("sub_ovf_sum", 32'(sum), 32'h7F);
    chk("sub_ovf_cout", 32'(carryout), 32'd1);
    chk("sub_ovf_ovf", 32'(overflow), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
